// File: rtl/qs_fifo_push_arb.sv
// Round-robin arbiter sharing one qs_fifo push port between NUM_REQ valid/ready producers.
// Optional per-requester accepted-word counters under `QS_FIFO_ARB_STATS_EN.
module qs_fifo_push_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      fifo_full_i,
  output logic                      push_o,
  output logic [DATA_W-1:0]         push_data_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o,
  output logic [16*NUM_REQ-1:0]     stat_cnt_o
);

  // state  | meaning
  // IDLE   | no owner; pick next valid requester from rr_ptr upward (one cycle)
  // GRANT  | owner pushes up to BURST_MAX words, stalled while the FIFO is full
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;
  logic [7:0]        burst_cnt;

  logic              hi_found;
  logic [ID_W-1:0]   hi_id;
  logic [ID_W-1:0]   lo_id;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   owner_next;
  logic              any_valid;
  logic              busy;
  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;
  logic              accept;
  logic              last_word;
  logic              release_grant;

  // Descending scan leaves the lowest matching index; hi_* only considers indices at or above rr_ptr.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        lo_id = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
  end

  assign any_valid = |req_valid_i;
  assign pick_id   = hi_found ? hi_id : lo_id;
  assign busy      = (state == ST_GRANT);

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == owner) begin
        owner_valid = req_valid_i[i];
        owner_data  = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept        = busy & owner_valid & ~fifo_full_i;
  assign last_word     = ({1'b0, burst_cnt} + 9'd1) == 9'(BURST_MAX);
  assign release_grant = busy & (~owner_valid | (accept & last_word));
  assign owner_next    = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (any_valid) begin
        owner     <= pick_id;
        burst_cnt <= '0;
        state     <= ST_GRANT;
      end
    end else begin
      if (release_grant) begin
        state  <= ST_IDLE;
        rr_ptr <= owner_next;
      end else if (accept) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i]     = busy && (owner == ID_W'(i));
      req_ready_o[i] = grant_o[i] & ~fifo_full_i;
    end
  end

  assign push_o      = accept;
  assign push_data_o = busy ? owner_data : '0;
  assign grant_id_o  = busy ? owner : '0;
  assign busy_o      = busy;

`ifdef QS_FIFO_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (owner == ID_W'(i)) && (stat_cnt[i] != 16'hFFFF))
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_cnt_o[i*16 +: 16] = stat_cnt[i];
  end
`else
  assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_qs_fifo_push_arb.sv
// Directed testbench for qs_fifo_push_arb (NUM_REQ=4, DATA_W=8, BURST_MAX=4).
// Producers are modelled as word counters that honour the valid/ready handshake.
module tb_qs_fifo_push_arb;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        fifo_full_i;
  logic        push_o;
  logic [7:0]  push_data_o;
  logic [3:0]  grant_o;
  logic [1:0]  grant_id_o;
  logic        busy_o;
  logic [63:0] stat_cnt_o;

  qs_fifo_push_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .fifo_full_i(fifo_full_i), .push_o(push_o),
    .push_data_o(push_data_o), .grant_o(grant_o), .grant_id_o(grant_id_o),
    .busy_o(busy_o), .stat_cnt_o(stat_cnt_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int         rem [4];
  logic [7:0] nxt [4];
  logic       full_v;

  logic        s_push, s_busy;
  logic [3:0]  s_ready, s_grant;
  logic [1:0]  s_gid;
  logic [7:0]  s_data;
  logic [63:0] s_stat;

  logic [7:0] log_data [$];
  logic [1:0] log_id [$];

  // One clock: drive producers, sample at the falling edge, account handshakes, move past the rising edge.
  task automatic step();
    for (int i = 0; i < 4; i++) begin
      req_valid_i[i]        = rem[i] > 0;
      req_data_i[i*8 +: 8]  = nxt[i];
    end
    fifo_full_i = full_v;
    @(negedge clk);
    s_push = push_o; s_busy = busy_o; s_ready = req_ready_o; s_grant = grant_o;
    s_gid = grant_id_o; s_data = push_data_o; s_stat = stat_cnt_o;
    if (push_o) begin
      log_data.push_back(push_data_o);
      log_id.push_back(grant_id_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid_i[i] && req_ready_o[i]) begin
        rem[i]--;
        nxt[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      nxt[i] = 8'h5A;
    end
    full_v      = 1'b0;
    req_valid_i = '0;
    req_data_i  = {4{8'h5A}};
    fifo_full_i = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if ({push_o, busy_o, req_ready_o, grant_o, grant_id_o, push_data_o, stat_cnt_o} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got push=%0b busy=%0b ready=%0h grant=%0h id=%0d data=%0h stat=%0h required all 0",
               push_o, busy_o, req_ready_o, grant_o, grant_id_o, push_data_o, stat_cnt_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    log_data.delete();
    log_id.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      nvec++;
      if ({s_push, s_busy, s_ready, s_grant, s_gid, s_data, s_stat} !== '0) begin
        nerr++;
        $display("FAIL idle_outputs c%0d: got push=%0b busy=%0b ready=%0h grant=%0h id=%0d data=%0h required all 0",
                 c, s_push, s_busy, s_ready, s_grant, s_gid, s_data);
      end
    end
  endtask

  task automatic test_single();
    logic exp_push [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    rem[2] = 8;
    nxt[2] = 8'hA0;
    for (int c = 0; c < 11; c++) begin
      step();
      nvec++;
      if (s_push !== exp_push[c] || s_busy !== exp_push[c]) begin
        nerr++;
        $display("FAIL single_push c%0d: got push=%0b busy=%0b required %0b", c, s_push, s_busy, exp_push[c]);
      end
      if (exp_push[c]) begin
        nvec++;
        if (s_gid !== 2'd2 || s_grant !== 4'b0100 || s_ready !== 4'b0100) begin
          nerr++;
          $display("FAIL single_owner c%0d: got id=%0d grant=%0h ready=%0h required 2/4/4", c, s_gid, s_grant, s_ready);
        end
      end
    end
    nvec++;
    if (log_data.size() != 8) begin
      nerr++;
      $display("FAIL single_count: got %0d words required 8", log_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        nvec++;
        if (log_data[k] !== 8'hA0 + 8'(k)) begin
          nerr++;
          $display("FAIL single_data w%0d: got %0h required %0h", k, log_data[k], 8'hA0 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [1:0] eid;
    logic [7:0] edat;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 100;
      nxt[i] = 8'(i * 16);
    end
    for (int c = 0; c < 25; c++) begin
      step();
      nvec++;
      if (s_busy !== ((c % 5) != 0)) begin
        nerr++;
        $display("FAIL fair_busy c%0d: got %0b required %0b", c, s_busy, (c % 5) != 0);
      end
      if (s_busy) begin
        nvec++;
        if (s_grant !== (4'b0001 << s_gid) || s_gid !== 2'((c / 5) % 4)) begin
          nerr++;
          $display("FAIL fair_grant c%0d: got grant=%0h id=%0d required id=%0d", c, s_grant, s_gid, (c / 5) % 4);
        end
      end
    end
    nvec++;
    if (log_data.size() != 20) begin
      nerr++;
      $display("FAIL fair_count: got %0d words required 20", log_data.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        eid  = 2'((k / 4) % 4);
        edat = {2'b00, eid, 4'((k / 16) * 4 + (k % 4))};
        nvec++;
        if (log_id[k] !== eid || log_data[k] !== edat) begin
          nerr++;
          $display("FAIL fair_word w%0d: got id=%0d data=%0h required id=%0d data=%0h", k, log_id[k], log_data[k], eid, edat);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    rem[1] = 6;
    nxt[1] = 8'h10;
    step();
    step();
    step();
    full_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      nvec++;
      if (s_push !== 1'b0 || s_ready !== 4'b0000 || s_busy !== 1'b1 || s_gid !== 2'd1) begin
        nerr++;
        $display("FAIL stall c%0d: got push=%0b ready=%0h busy=%0b id=%0d required 0/0/1/1", c, s_push, s_ready, s_busy, s_gid);
      end
    end
    full_v = 1'b0;
    step();
    nvec++;
    if (s_push !== 1'b1 || s_data !== 8'h12) begin
      nerr++;
      $display("FAIL stall_resume: got push=%0b data=%0h required 1/12", s_push, s_data);
    end
    step();
    step();
    nvec++;
    if (s_busy !== 1'b0) begin
      nerr++;
      $display("FAIL stall_release: got busy=%0b required 0", s_busy);
    end
    nvec++;
    if (log_data.size() != 4 || log_data[0] !== 8'h10 || log_data[1] !== 8'h11 ||
        log_data[2] !== 8'h12 || log_data[3] !== 8'h13) begin
      nerr++;
      $display("FAIL stall_words: got %0d words required 10,11,12,13", log_data.size());
    end
  endtask

  task automatic test_early_release();
    do_reset();
    rem[3] = 2;
    nxt[3] = 8'h30;
    step();
    step();
    step();
    rem[0] = 2; nxt[0] = 8'h40;
    rem[1] = 2; nxt[1] = 8'h50;
    step();
    nvec++;
    if (s_busy !== 1'b1 || s_gid !== 2'd3 || s_push !== 1'b0) begin
      nerr++;
      $display("FAIL early_drop: got busy=%0b id=%0d push=%0b required 1/3/0", s_busy, s_gid, s_push);
    end
    step();
    nvec++;
    if (s_busy !== 1'b0) begin
      nerr++;
      $display("FAIL early_idle: got busy=%0b required 0", s_busy);
    end
    step();
    nvec++;
    if (s_gid !== 2'd0 || s_grant !== 4'b0001 || s_push !== 1'b1 || s_data !== 8'h40) begin
      nerr++;
      $display("FAIL early_next: got id=%0d grant=%0h push=%0b data=%0h required 0/1/1/40", s_gid, s_grant, s_push, s_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[0] = 10;
    nxt[0] = 8'h70;
    step();
    step();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    nvec++;
    if (busy_o !== 1'b0 || push_o !== 1'b0 || grant_o !== 4'b0 || req_ready_o !== 4'b0) begin
      nerr++;
      $display("FAIL midreset: got busy=%0b push=%0b grant=%0h ready=%0h required 0", busy_o, push_o, grant_o, req_ready_o);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stats();
    logic [63:0] exp_stat;
`ifdef QS_FIFO_ARB_STATS_EN
    exp_stat = {16'd0, 16'd3, 16'd0, 16'd6};
`else
    exp_stat = '0;
`endif
    do_reset();
    rem[0] = 6; nxt[0] = 8'h00;
    rem[2] = 3; nxt[2] = 8'h20;
    for (int c = 0; c < 16; c++) step();
    nvec++;
    if (s_stat !== exp_stat) begin
      nerr++;
      $display("FAIL stats: got %0h required %0h", s_stat, exp_stat);
    end
    nvec++;
    if (log_data.size() != 9) begin
      nerr++;
      $display("FAIL stats_words: got %0d required 9", log_data.size());
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    fifo_full_i = 1'b0;
    full_v      = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
